ifetch: RTL and testbench

- Instruction fetch unit: the producer side of the opcode interface.
- Reads opcode and operand bytes from memory.
- Sizes each instruction from its opcode and presents {opcode, operand, length, pc} to the decode/execute stage with a valid/ready handshake.
- Injects BRK (8'h00) on pending NMI/IRQ, so the downstream decoder sees interrupts as ordinary opcodes.

---
 rtl/ifetch.sv | 176 +++++++++++++++++
 tb/tb_ifetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: sizes opcodes, gathers operands, injects BRK on NMI/IRQ.
// Optional trace counter/port pair enabled by IFETCH_TRACE_EN.
module ifetch #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    input  logic        i_flag,
    input  logic        irq_n,
    input  logic        nmi_n,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_rdata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    output logic [1:0]  op_len,
    output logic [15:0] op_pc,
    output logic        op_int,
    output logic        op_nmi
`ifdef IFETCH_TRACE_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [15:0] trace_pc
`endif
);

    typedef enum logic [1:0] {REQ, CAP, VALID} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [1:0]  idx;
    logic        fresh;
    logic [7:0]  b0, b1;
    logic        nmi_prev, nmi_pend;
    logic        inject, hs, done;
    logic [7:0]  op_src;
    logic [1:0]  len;

    function automatic logic [1:0] len_of(input logic [7:0] o);
        logic [1:0] l;
        l = 2'd2;
        unique case (1'b1)
            (o != 8'h00) && (o[3:2] == 2'b10) && !o[0]:
                l = 2'd1;
            (o == 8'h20) || (o[3:2] == 2'b11) || ((o[4:2] == 3'b110) && o[0]):
                l = 2'd3;
            default:
                l = 2'd2;
        endcase
        return l;
    endfunction

    // fresh marks the first REQ cycle of a new instruction; only then may an
    // interrupt pre-empt the opcode read, so a stalled request keeps its address.
    assign inject = (state == REQ) && fresh && (nmi_pend || (!irq_n && !i_flag));
    assign hs     = (state == VALID) && op_ready;
    assign op_src = (idx == 2'd0) ? mem_rdata : b0;
    assign len    = len_of(op_src);
    assign done   = ({1'b0, idx} + 3'd1) >= {1'b0, len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= REQ;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pc_load) begin
            state_nxt = REQ;
        end else begin
            unique case (state)
                REQ:     if (inject) state_nxt = VALID;
                         else if (mem_rdy) state_nxt = CAP;
                CAP:     state_nxt = done ? VALID : REQ;
                VALID:   if (op_ready) state_nxt = REQ;
                default: state_nxt = REQ;
            endcase
        end
    end

    always_comb begin
        mem_rd   = rst_n && (state == REQ) && !inject;
        mem_addr = mem_rd ? pc + {14'b0, idx} : 16'h0000;
        op_valid = (state == VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_RESET;
            idx     <= 2'd0;
            fresh   <= 1'b1;
            b0      <= 8'h00;
            b1      <= 8'h00;
            opcode  <= 8'h00;
            operand <= 16'h0000;
            op_len  <= 2'd0;
            op_pc   <= 16'h0000;
            op_int  <= 1'b0;
            op_nmi  <= 1'b0;
        end else if (pc_load) begin
            pc    <= pc_in;
            idx   <= 2'd0;
            fresh <= 1'b1;
        end else begin
            unique case (state)
                REQ: begin
                    fresh <= 1'b0;
                    if (inject) begin
                        opcode  <= 8'h00;
                        operand <= 16'h0000;
                        op_len  <= 2'd0;
                        op_pc   <= pc;
                        op_int  <= 1'b1;
                        op_nmi  <= nmi_pend;
                    end
                end
                CAP: begin
                    if (idx == 2'd0) b0 <= mem_rdata;
                    if (idx == 2'd1) b1 <= mem_rdata;
                    if (!done) begin
                        idx <= idx + 2'd1;
                    end else begin
                        opcode <= op_src;
                        op_len <= len;
                        op_pc  <= pc;
                        op_int <= 1'b0;
                        op_nmi <= 1'b0;
                        unique case (idx)
                            2'd0:    operand <= 16'h0000;
                            2'd1:    operand <= {8'h00, mem_rdata};
                            default: operand <= {mem_rdata, b1};
                        endcase
                    end
                end
                VALID: begin
                    if (op_ready) begin
                        pc    <= pc + {14'b0, op_len};
                        idx   <= 2'd0;
                        fresh <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new falling edge outranks the clear, so an NMI during its own BRK re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            if (nmi_prev && !nmi_n) nmi_pend <= 1'b1;
            else if (hs && op_nmi)  nmi_pend <= 1'b0;
        end
    end

`ifdef IFETCH_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 32'd0;
            trace_pc  <= 16'h0000;
        end else if (hs) begin
            instr_cnt <= instr_cnt + 32'd1;
            trace_pc  <= op_pc;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed timing steps plus a randomized transaction-level run.
// Memory responder and random mem_rdy live in small always blocks.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        i_flag = 1'b1;
    logic        irq_n = 1'b1;
    logic        nmi_n = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic [7:0]  mem_rdata = 8'h00;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  op_len;
    logic [15:0] op_pc;
    logic        op_int;
    logic        op_nmi;
`ifdef IFETCH_TRACE_EN
    logic [31:0] instr_cnt;
    logic [15:0] trace_pc;
`endif

    logic        rdy_d = 1'b1;
    logic        rdy_r = 1'b1;
    logic        rdy_rand = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [15:0] req_addr [8];
    int          req_cnt = 0;
    int          base = 0;
    int          ntests = 0;
    int          nfail = 0;

    assign mem_rdy = rdy_rand ? rdy_r : rdy_d;

    ifetch dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
        .i_flag(i_flag), .irq_n(irq_n), .nmi_n(nmi_n),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_rdata(mem_rdata), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .op_len(op_len), .op_pc(op_pc),
        .op_int(op_int), .op_nmi(op_nmi)
`ifdef IFETCH_TRACE_EN
        , .instr_cnt(instr_cnt), .trace_pc(trace_pc)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) rdy_r = ($urandom_range(0, 3) != 0);

    // Accepted request -> data presented for the following cycle.
    always @(negedge clk) begin
        #2;
        if (mem_rd === 1'b1 && mem_rdy === 1'b1) begin
            mem_rdata = mem[mem_addr];
            req_addr[req_cnt % 8] = mem_addr;
            req_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (op_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", op_valid, 1);
    endtask

    task automatic accept();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] a);
        pc_load = 1'b1;
        pc_in = a;
        @(negedge clk);
        pc_load = 1'b0;
        base = req_cnt;
    endtask

    task automatic chk_log(input string tag, input int k,
                           input logic [15:0] exp);
        chk(tag, req_addr[(base + k) % 8], exp);
    endtask

    function automatic int exp_len(input int o);
        int nib, mid;
        nib = o % 16;
        mid = (o / 4) % 8;
        if (o != 0 && (nib == 8 || nib == 10)) return 1;
        if (o == 32 || mid == 3 || mid == 7 || (mid == 6 && (o % 2) == 1))
            return 3;
        return 2;
    endfunction

    initial begin
        int n;
        int el;
        logic [15:0] pc_m;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] eop;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        mem[16'h0300] = 8'h4C; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
        mem[16'h0600] = 8'hEA; mem[16'h0601] = 8'h0A;
        mem[16'h0400] = 8'hA9; mem[16'h0401] = 8'h11;
        mem[16'h0500] = 8'h20; mem[16'h0501] = 8'hAA; mem[16'h0502] = 8'hBB;
        mem[16'h8000] = 8'hEA;
        mem[16'hFFFF] = 8'h20; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h90;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_op_len", op_len, 0);
        chk("rst_op_pc", op_pc, 0);
        chk("rst_op_int", op_int, 0);
        chk("rst_op_nmi", op_nmi, 0);
`ifdef IFETCH_TRACE_EN
        chk("rst_instr_cnt", instr_cnt, 0);
        chk("rst_trace_pc", trace_pc, 0);
`endif

        // LDA # at 0200
        rst_n = 1'b1;
        redirect(16'h0200);
        chk("lda_rd", mem_rd, 1);
        chk("lda_addr0", mem_addr, 16'h0200);
        wait_valid(20, n);
        chk("lda_latency", n, 4);
        chk("lda_opcode", opcode, 8'hA9);
        chk("lda_operand", operand, 16'h0042);
        chk("lda_len", op_len, 2);
        chk("lda_pc", op_pc, 16'h0200);
        chk("lda_int", op_int, 0);
        chk("lda_nreq", req_cnt - base, 2);
        chk_log("lda_log1", 1, 16'h0201);
        accept();
        chk("lda_next_rd", mem_rd, 1);
        chk("lda_next_addr", mem_addr, 16'h0202);
        chk("lda_next_valid", op_valid, 0);

        // JMP abs at 0300 held for 5 cycles
        redirect(16'h0300);
        wait_valid(20, n);
        chk("jmp_latency", n, 6);
        repeat (5) begin
            @(negedge clk);
            chk("jmp_hold", {op_valid, 3'b0, op_len, operand, opcode},
                {1'b1, 3'b0, 2'd3, 16'h1234, 8'h4C});
        end
        accept();
        chk("jmp_next_addr", mem_addr, 16'h0303);
`ifdef IFETCH_TRACE_EN
        chk("trace_cnt", instr_cnt, 2);
        chk("trace_pc", trace_pc, 16'h0300);
`endif

        // NOP then ASL A with 3 stall cycles on the second request
        redirect(16'h0600);
        wait_valid(20, n);
        chk("nop_latency", n, 2);
        chk("nop_fields", {opcode, operand, 6'b0, op_len}, {8'hEA, 16'h0, 8'd1});
        accept();
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", {mem_rd, mem_addr}, {1'b1, 16'h0601});
            rdy_d = 1'b0;
            @(negedge clk);
        end
        chk("stall_addr_end", {mem_rd, mem_addr}, {1'b1, 16'h0601});
        rdy_d = 1'b1;
        wait_valid(20, n);
        chk("asl_latency", n + 3, 5);
        chk("asl_fields", {opcode, operand, 6'b0, op_len}, {8'h0A, 16'h0, 8'd1});

        // IRQ masked, then taken, then NMI priority
        irq_n = 1'b0;
        redirect(16'h0400);
        chk("irqm_addr", {mem_rd, mem_addr}, {1'b1, 16'h0400});
        wait_valid(20, n);
        chk("irqm_latency", n, 4);
        chk("irqm_fields", {op_int, opcode}, {1'b0, 8'hA9});
        i_flag = 1'b0;
        redirect(16'h0400);
        chk("irq_no_rd", mem_rd, 0);
        @(negedge clk);
        chk("irq_valid", op_valid, 1);
        chk("irq_fields", {opcode, op_int, op_nmi, op_len, op_pc},
            {8'h00, 1'b1, 1'b0, 2'd0, 16'h0400});
        chk("irq_nreq", req_cnt - base, 0);
        nmi_n = 1'b0;
        @(negedge clk);
        accept();
        chk("nmi_no_rd", mem_rd, 0);
        @(negedge clk);
        chk("nmi_fields", {op_valid, op_int, op_nmi, op_len, op_pc},
            {1'b1, 1'b1, 1'b1, 2'd0, 16'h0400});
        nmi_n = 1'b1;
        irq_n = 1'b1;
        i_flag = 1'b1;
        accept();
        chk("post_int_addr", {mem_rd, mem_addr}, {1'b1, 16'h0400});

        // redirect during CAP of a 3-byte fetch
        redirect(16'h0500);
        @(negedge clk);
        chk("cap_rd", mem_rd, 0);
        pc_load = 1'b1;
        pc_in = 16'h8000;
        @(negedge clk);
        pc_load = 1'b0;
        chk("redir_valid", op_valid, 0);
        chk("redir_addr", {mem_rd, mem_addr}, {1'b1, 16'h8000});
        wait_valid(20, n);
        chk("redir_latency", n, 2);
        chk("redir_fields", {opcode, op_pc}, {8'hEA, 16'h8000});
        accept();

        // JSR across the FFFF wrap
        redirect(16'hFFFF);
        wait_valid(20, n);
        chk("wrap_latency", n, 6);
        chk("wrap_fields", {operand, 6'b0, op_len, op_pc},
            {16'h9000, 8'd3, 16'hFFFF});
        chk_log("wrap_log1", 1, 16'h0000);
        chk_log("wrap_log2", 2, 16'h0001);
        accept();
        chk("wrap_next", mem_addr, 16'h0002);

        // random opcodes, random stalls and consumer delays
        rdy_rand = 1'b1;
        redirect(16'h1000);
        pc_m = 16'h1000;
        for (int k = 0; k < 40; k++) begin
            wait_valid(80, n);
            el = exp_len(int'(mem[pc_m]));
            a1 = pc_m + 16'd1;
            a2 = pc_m + 16'd2;
            eop = (el == 1) ? 16'h0000 :
                  (el == 2) ? {8'h00, mem[a1]} : {mem[a2], mem[a1]};
            chk("rnd_opcode", opcode, mem[pc_m]);
            chk("rnd_len", op_len, el);
            chk("rnd_operand", operand, eop);
            chk("rnd_pc", op_pc, pc_m);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept();
            pc_m = pc_m + 16'(el);
        end
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
